ldpc_cyclic_shuffle: RTL

LDPC_CYCLIC_SHUFFLE -- requirements
Module: ldpc_cyclic_shuffle

---
 rtl/ldpc_cyclic_shuffle.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ldpc_cyclic_shuffle.sv
// Three-stage cyclic lane rotator for QC-LDPC message routing: rotates the first z
// lanes by s (forward or inverse) with valid/ready flow control and a sideband tag.
module ldpc_cyclic_shuffle #(
  parameter int NUMLANES   = 90,
  parameter int LLRWIDTH   = 4,
  parameter int SHIFTWIDTH = 7,
  parameter int TAGWIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_dir,
  input  logic [SHIFTWIDTH-1:0]        in_shift,
  input  logic [SHIFTWIDTH-1:0]        in_zsize,
  input  logic [NUMLANES*LLRWIDTH-1:0] in_data,
  input  logic [TAGWIDTH-1:0]          in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUMLANES*LLRWIDTH-1:0] out_data,
  output logic [TAGWIDTH-1:0]          out_tag,
  output logic                         out_err
);

  localparam int W     = NUMLANES * LLRWIDTH;
  localparam int FINEW = SHIFTWIDTH / 3;
  localparam int RESW  = 2 * (SHIFTWIDTH / 3);
  localparam logic [SHIFTWIDTH-1:0] FINE_MASK = SHIFTWIDTH'((1 << FINEW) - 1);
  localparam logic [SHIFTWIDTH-1:0] RES_MASK  = SHIFTWIDTH'((1 << RESW) - 1);

  // Rotation by amt modulo z over the first z lanes; lanes at or above z read as zero.
  // Partial rotations modulo the same z compose additively, so the shift is split
  // into coarse/medium/fine chunks applied one per stage.
  function automatic logic [W-1:0] rotate_lanes(input logic [W-1:0] d, input logic dir,
                                                input logic [SHIFTWIDTH-1:0] amt,
                                                input logic [SHIFTWIDTH-1:0] z);
    logic [W-1:0] r;
    int zi, ai, src;
    r  = '0;
    zi = int'(z);
    ai = int'(amt);
    for (int j = 0; j < NUMLANES; j++) begin
      if (j < zi) begin
        if (dir) src = (j + ai >= zi) ? j + ai - zi : j + ai;
        else     src = (j >= ai) ? j - ai : j - ai + zi;
        if (src >= 0 && src < NUMLANES) r[j*LLRWIDTH +: LLRWIDTH] = d[src*LLRWIDTH +: LLRWIDTH];
      end
    end
    return r;
  endfunction

  logic                  s1_valid, s2_valid, s3_valid;
  logic [W-1:0]          s1_data, s2_data, s3_data;
  logic [TAGWIDTH-1:0]   s1_tag, s2_tag, s3_tag;
  logic                  s1_dir, s2_dir, s3_dir;
  logic [SHIFTWIDTH-1:0] s1_shift, s2_shift, s3_shift;
  logic [SHIFTWIDTH-1:0] s1_zsize, s2_zsize, s3_zsize;
  logic                  s1_err, s2_err, s3_err;
  logic                  ld1, ld2, ld3, in_err;
  logic [W-1:0]          coarse_data, medium_data;

  assign ld3      = ~s3_valid | out_ready;
  assign ld2      = ~s2_valid | ld3;
  assign ld1      = ~s1_valid | ld2;
  assign in_ready = ld1 & ~rst;
  assign in_err   = (in_zsize == '0) || (int'(in_zsize) > NUMLANES) || (in_shift >= in_zsize);

  assign coarse_data = rotate_lanes(s1_data, s1_dir, s1_shift & ~RES_MASK, s1_zsize);
  assign medium_data = rotate_lanes(s2_data, s2_dir, s2_shift & ~FINE_MASK, s2_zsize);

  // Illegal beats are zeroed on entry so later rotations never see real data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_data <= '0; s1_tag <= '0; s1_dir <= 1'b0;
      s1_shift <= '0; s1_zsize <= '0; s1_err <= 1'b0;
    end else if (ld1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_err ? '0 : in_data;
        s1_tag   <= in_tag;
        s1_dir   <= in_dir;
        s1_shift <= in_shift;
        s1_zsize <= in_zsize;
        s1_err   <= in_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0; s2_data <= '0; s2_tag <= '0; s2_dir <= 1'b0;
      s2_shift <= '0; s2_zsize <= '0; s2_err <= 1'b0;
    end else if (ld2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data  <= coarse_data;
        s2_tag   <= s1_tag;
        s2_dir   <= s1_dir;
        s2_shift <= s1_shift & RES_MASK;
        s2_zsize <= s1_zsize;
        s2_err   <= s1_err;
      end
    end
  end

  // Output stage only reloads on ld3, so its contents hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0; s3_data <= '0; s3_tag <= '0; s3_dir <= 1'b0;
      s3_shift <= '0; s3_zsize <= '0; s3_err <= 1'b0;
    end else if (ld3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_data  <= medium_data;
        s3_tag   <= s2_tag;
        s3_dir   <= s2_dir;
        s3_shift <= s2_shift & FINE_MASK;
        s3_zsize <= s2_zsize;
        s3_err   <= s2_err;
      end
    end
  end

  assign out_valid = s3_valid;
  assign out_tag   = s3_tag;
  assign out_err   = s3_err;
  assign out_data  = s3_err ? '0 : rotate_lanes(s3_data, s3_dir, s3_shift, s3_zsize);

endmodule
